screen_sequencer: RTL and testbench

// - Game-screen controller for Flappy Bird: FSM START -> GAME -> GAMEOVER -> START.
// - Selects which of the three screen RGB sources (start/game/gameover + valids) drives the VGA pixel output.
// - Changes screen only on a frame boundary; pulses game_rst on entry to GAME.
// - Sits between the three draw pipelines and the VGA output register.

---
 rtl/screen_sequencer.sv | 146 ++++++++++++++
 tb/tb_screen_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/screen_sequencer.sv
// Flappy Bird screen controller: START -> GAME -> GAMEOVER FSM plus registered RGB source mux.
// Optional SCREEN_FADE_EN adds a 4-frame fade-in after every screen change.
module screen_sequencer #(
  parameter int          OVER_HOLD_FRAMES = 60,
  parameter logic [11:0] BG_COLOR         = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        blank,
  input  logic        start_btn,
  input  logic        collision,
  input  logic [11:0] rgb_start,
  input  logic [11:0] rgb_game,
  input  logic [11:0] rgb_gameover,
  input  logic        valid_start,
  input  logic        valid_game,
  input  logic        valid_gameover,
  output logic [11:0] rgb_out,
  output logic [1:0]  screen,
  output logic        game_active,
  output logic        game_rst
);

  localparam int                HOLD_W   = $clog2(OVER_HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD_FRAMES);

  typedef enum logic [1:0] {
    SCR_START = 2'd0,
    SCR_GAME  = 2'd1,
    SCR_OVER  = 2'd2
  } screen_t;

  screen_t           state;
  logic              pending;
  logic [HOLD_W-1:0] hold_cnt;
  logic              req;
  logic              pend_next;
  logic              legal;
  logic              advance;

  logic [11:0]       rgb_p0;
  logic              vld_p0;
  logic [11:0]       pix_p0;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + HOLD_W'(1);
  endfunction

  function automatic screen_t next_screen(input screen_t s);
    case (s)
      SCR_START: return SCR_GAME;
      SCR_GAME:  return SCR_OVER;
      default:   return SCR_START;
    endcase
  endfunction

  function automatic logic [11:0] fade_px(input logic [11:0] px, input logic [1:0] lvl);
    return {px[11:8] >> lvl, px[7:4] >> lvl, px[3:0] >> lvl};
  endfunction

  // Request decode: collision has priority in GAME because start_btn is ignored there.
  always_comb begin
    req = 1'b0;
    case (state)
      SCR_START: req = start_btn;
      SCR_GAME:  req = collision;
      SCR_OVER:  req = start_btn && (hold_cnt == HOLD_MAX);
      default:   req = 1'b0;
    endcase
  end

  assign pend_next = pending | req;
  assign legal     = (state == SCR_START) || (state == SCR_GAME) || (state == SCR_OVER);
  assign advance   = legal && frame_start && pend_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCR_START;
      pending     <= 1'b0;
      hold_cnt    <= '0;
      game_rst    <= 1'b0;
      game_active <= 1'b0;
    end else begin
      game_rst <= 1'b0;
      if (!legal) begin
        state       <= SCR_START;
        pending     <= 1'b0;
        game_active <= 1'b0;
      end else if (advance) begin
        state       <= next_screen(state);
        pending     <= 1'b0;
        game_rst    <= (state == SCR_START);
        game_active <= (state == SCR_START);
        if (state == SCR_GAME) hold_cnt <= '0;
      end else begin
        pending <= pend_next;
        if ((state == SCR_OVER) && frame_start) hold_cnt <= sat_inc(hold_cnt);
      end
    end
  end

  assign screen = state;

`ifdef SCREEN_FADE_EN
  logic [1:0] fade_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fade_lvl <= 2'd0;
    end else if (advance || !legal) begin
      fade_lvl <= 2'd3;
    end else if (frame_start && (fade_lvl != 2'd0)) begin
      fade_lvl <= fade_lvl - 2'd1;
    end
  end
`endif

  // Stage p0: source select on the pre-update screen, background substitution.
  always_comb begin
    rgb_p0 = 12'h000;
    vld_p0 = 1'b0;
    case (state)
      SCR_START: begin rgb_p0 = rgb_start;    vld_p0 = valid_start;    end
      SCR_GAME:  begin rgb_p0 = rgb_game;     vld_p0 = valid_game;     end
      SCR_OVER:  begin rgb_p0 = rgb_gameover; vld_p0 = valid_gameover; end
      default:   begin rgb_p0 = 12'h000;      vld_p0 = 1'b0;           end
    endcase
  end

`ifdef SCREEN_FADE_EN
  assign pix_p0 = fade_px(vld_p0 ? rgb_p0 : BG_COLOR, fade_lvl);
`else
  assign pix_p0 = vld_p0 ? rgb_p0 : BG_COLOR;
`endif

  // Stage p1: output register toward the VGA port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out <= 12'h000;
    end else begin
      rgb_out <= blank ? 12'h000 : pix_p0;
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with OVER_HOLD_FRAMES=2 and a non-zero background colour.
module tb_screen_sequencer;

  localparam logic [11:0] BG = 12'h5A3;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        blank;
  logic        start_btn;
  logic        collision;
  logic [11:0] rgb_start;
  logic [11:0] rgb_game;
  logic [11:0] rgb_gameover;
  logic        valid_start;
  logic        valid_game;
  logic        valid_gameover;
  logic [11:0] rgb_out;
  logic [1:0]  screen;
  logic        game_active;
  logic        game_rst;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  screen_sequencer #(
    .OVER_HOLD_FRAMES(2),
    .BG_COLOR(BG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .blank(blank),
    .start_btn(start_btn),
    .collision(collision),
    .rgb_start(rgb_start),
    .rgb_game(rgb_game),
    .rgb_gameover(rgb_gameover),
    .valid_start(valid_start),
    .valid_game(valid_game),
    .valid_gameover(valid_gameover),
    .rgb_out(rgb_out),
    .screen(screen),
    .game_active(game_active),
    .game_rst(game_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] faded(input logic [11:0] p, input int lvl);
`ifdef SCREEN_FADE_EN
    return {p[11:8] >> lvl, p[7:4] >> lvl, p[3:0] >> lvl};
`else
    return (lvl >= 0) ? p : 12'h000;
`endif
  endfunction

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (screen !== 2'd0) $display("FAIL rst_screen got=%0d exp=0", screen); else pass_cnt++;
    chk_cnt++; if (rgb_out !== 12'h000) $display("FAIL rst_rgb got=%h exp=000", rgb_out); else pass_cnt++;
    chk_cnt++; if (game_active !== 1'b0) $display("FAIL rst_active got=%b exp=0", game_active); else pass_cnt++;
    chk_cnt++; if (game_rst !== 1'b0) $display("FAIL rst_game_rst got=%b exp=0", game_rst); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pixel_start();
    blank = 1'b0; valid_start = 1'b1; rgb_start = 12'hABC;
    @(negedge clk);
    chk_cnt++; if (rgb_out !== 12'hABC) $display("FAIL start_pix got=%h exp=abc", rgb_out); else pass_cnt++;
    chk_cnt++; if (screen !== 2'd0) $display("FAIL start_screen got=%0d exp=0", screen); else pass_cnt++;
  endtask

  task automatic test_start_to_game();
    rgb_game = 12'h123; valid_game = 1'b1;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    repeat (49) @(negedge clk);
    chk_cnt++; if (screen !== 2'd0) $display("FAIL s2g_wait_screen got=%0d exp=0", screen); else pass_cnt++;
    chk_cnt++; if (game_rst !== 1'b0) $display("FAIL s2g_wait_rst got=%b exp=0", game_rst); else pass_cnt++;
    pulse_frame();
    chk_cnt++; if (screen !== 2'd1) $display("FAIL s2g_screen got=%0d exp=1", screen); else pass_cnt++;
    chk_cnt++; if (game_rst !== 1'b1) $display("FAIL s2g_game_rst got=%b exp=1", game_rst); else pass_cnt++;
    chk_cnt++; if (game_active !== 1'b1) $display("FAIL s2g_active got=%b exp=1", game_active); else pass_cnt++;
    chk_cnt++; if (rgb_out !== 12'hABC) $display("FAIL s2g_old_pix got=%h exp=abc", rgb_out); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (game_rst !== 1'b0) $display("FAIL s2g_rst_pulse got=%b exp=0", game_rst); else pass_cnt++;
    chk_cnt++; if (rgb_out !== faded(12'h123, 3)) $display("FAIL s2g_new_pix got=%h exp=%h", rgb_out, faded(12'h123, 3)); else pass_cnt++;
  endtask

  task automatic test_collision_wins();
    collision = 1'b1; start_btn = 1'b1;
    @(negedge clk);
    collision = 1'b0; start_btn = 1'b0;
    chk_cnt++; if (screen !== 2'd1) $display("FAIL col_hold_screen got=%0d exp=1", screen); else pass_cnt++;
    repeat (3) @(negedge clk);
    pulse_frame();
    chk_cnt++; if (screen !== 2'd2) $display("FAIL col_screen got=%0d exp=2", screen); else pass_cnt++;
    chk_cnt++; if (game_rst !== 1'b0) $display("FAIL col_game_rst got=%b exp=0", game_rst); else pass_cnt++;
    chk_cnt++; if (game_active !== 1'b0) $display("FAIL col_active got=%b exp=0", game_active); else pass_cnt++;
  endtask

  task automatic test_gameover_hold();
    repeat (2) @(negedge clk);
    pulse_frame();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    repeat (2) @(negedge clk);
    pulse_frame();
    chk_cnt++; if (screen !== 2'd2) $display("FAIL over_early_screen got=%0d exp=2", screen); else pass_cnt++;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    chk_cnt++; if (screen !== 2'd2) $display("FAIL over_pend_screen got=%0d exp=2", screen); else pass_cnt++;
    repeat (2) @(negedge clk);
    pulse_frame();
    chk_cnt++; if (screen !== 2'd0) $display("FAIL over_exit_screen got=%0d exp=0", screen); else pass_cnt++;
    chk_cnt++; if (game_rst !== 1'b0) $display("FAIL over_exit_rst got=%b exp=0", game_rst); else pass_cnt++;
  endtask

  task automatic test_bg_blank();
    start_btn = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    start_btn = 1'b0; frame_start = 1'b0;
    chk_cnt++; if (screen !== 2'd1) $display("FAIL same_cyc_screen got=%0d exp=1", screen); else pass_cnt++;
    chk_cnt++; if (game_rst !== 1'b1) $display("FAIL same_cyc_rst got=%b exp=1", game_rst); else pass_cnt++;
    valid_game = 1'b0;
    @(negedge clk);
    chk_cnt++; if (rgb_out !== faded(BG, 3)) $display("FAIL bg_pix got=%h exp=%h", rgb_out, faded(BG, 3)); else pass_cnt++;
    blank = 1'b1;
    @(negedge clk);
    chk_cnt++; if (rgb_out !== 12'h000) $display("FAIL blank_pix got=%h exp=000", rgb_out); else pass_cnt++;
    blank = 1'b0;
  endtask

`ifdef SCREEN_FADE_EN
  task automatic test_fade();
    logic [11:0] exp_seq [4];
    exp_seq[0] = 12'h111; exp_seq[1] = 12'h333; exp_seq[2] = 12'h777; exp_seq[3] = 12'hFFF;
    valid_game = 1'b1; rgb_game = 12'hFFF;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (rgb_out !== exp_seq[i]) $display("FAIL fade_%0d got=%h exp=%h", i, rgb_out, exp_seq[i]); else pass_cnt++;
      pulse_frame();
      @(negedge clk);
    end
    chk_cnt++; if (rgb_out !== 12'hFFF) $display("FAIL fade_end got=%h exp=fff", rgb_out); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid();
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (screen !== 2'd0) $display("FAIL mid_rst_screen got=%0d exp=0", screen); else pass_cnt++;
    chk_cnt++; if (game_active !== 1'b0) $display("FAIL mid_rst_active got=%b exp=0", game_active); else pass_cnt++;
    chk_cnt++; if (rgb_out !== 12'h000) $display("FAIL mid_rst_rgb got=%h exp=000", rgb_out); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_frame();
    chk_cnt++; if (screen !== 2'd0) $display("FAIL mid_rst_pend_lost got=%0d exp=0", screen); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; blank = 1'b1; start_btn = 1'b0; collision = 1'b0;
    rgb_start = 12'h000; rgb_game = 12'h000; rgb_gameover = 12'h0F0;
    valid_start = 1'b0; valid_game = 1'b0; valid_gameover = 1'b1;
    test_reset();
    test_pixel_start();
    test_start_to_game();
    test_collision_wins();
    test_gameover_hold();
    test_bg_blank();
`ifdef SCREEN_FADE_EN
    test_fade();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
